// File: rtl/kernel_stall_detector.sv
// rtl/kernel_stall_detector.sv - kernel deadlock detector: declares block after THRESHOLD+1 stable stall cycles
// Optional macro DEADLOCK_STICKY_EN makes BLOCKED terminal until reset.
module kernel_stall_detector #(
    parameter int AXIS_W    = 2,
    parameter int IDLE_W    = 3,
    parameter int BLK_W     = 1,
    parameter int THRESHOLD = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [AXIS_W-1:0] axis_block_sigs,
    input  logic [IDLE_W-1:0] inst_idle_sigs,
    input  logic [BLK_W-1:0]  inst_block_sigs,
    output logic              block,
    output logic [AXIS_W-1:0] blk_axis,
    output logic [31:0]       blk_cycles
);

    localparam int SIG_W = AXIS_W + BLK_W;
    localparam logic [15:0] TH = 16'(THRESHOLD);

    typedef enum logic [1:0] {
        MON     = 2'd0,
        SUSPECT = 2'd1,
        BLOCKED = 2'd2
    } state_t;

    state_t            r_state;
    logic [15:0]       r_cnt;
    logic [SIG_W-1:0]  r_sig_q;
    logic              r_block;
    logic [AXIS_W-1:0] r_blk_axis;
    logic [31:0]       r_blk_cycles;

    logic              w_stall;
    logic [SIG_W-1:0]  w_sig;
    logic              w_progress;

    // A fully idle kernel cannot be deadlocked, whatever the blocking flags say.
    assign w_stall    = ((|axis_block_sigs) | (|inst_block_sigs)) & ~(&inst_idle_sigs);
    assign w_sig      = {axis_block_sigs, inst_block_sigs};
    assign w_progress = ~w_stall | (w_sig != r_sig_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= MON;
            r_cnt        <= 16'd0;
            r_sig_q      <= '0;
            r_block      <= 1'b0;
            r_blk_axis   <= '0;
            r_blk_cycles <= 32'd0;
        end else begin
            r_sig_q <= w_sig;
            case (r_state)
                MON: begin
                    if (w_stall) begin
                        r_state <= SUSPECT;
                        r_cnt   <= 16'd1;
                    end else begin
                        r_cnt   <= 16'd0;
                    end
                end
                SUSPECT: begin
                    if (w_progress) begin
                        r_state <= MON;
                        r_cnt   <= 16'd0;
                    end else if (r_cnt == TH) begin
                        r_state      <= BLOCKED;
                        r_block      <= 1'b1;
                        r_blk_axis   <= axis_block_sigs;
                        r_blk_cycles <= 32'd1;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                BLOCKED: begin
`ifdef DEADLOCK_STICKY_EN
                    if (r_blk_cycles != 32'hFFFF_FFFF)
                        r_blk_cycles <= r_blk_cycles + 32'd1;
`else
                    // Any signature change or stall release means the kernel moved again.
                    if (w_progress) begin
                        r_state <= MON;
                        r_block <= 1'b0;
                        r_cnt   <= 16'd0;
                    end else if (r_blk_cycles != 32'hFFFF_FFFF) begin
                        r_blk_cycles <= r_blk_cycles + 32'd1;
                    end
`endif
                end
                default: begin
                    r_state <= MON;
                    r_cnt   <= 16'd0;
                    r_block <= 1'b0;
                end
            endcase
        end
    end

    assign block      = r_block;
    assign blk_axis   = r_blk_axis;
    assign blk_cycles = r_blk_cycles;

endmodule

// File: tb/tb_kernel_stall_detector.sv
// tb/tb_kernel_stall_detector.sv - scoreboard bench for kernel_stall_detector with a run-length reference model
module tb_kernel_stall_detector;

    localparam int TH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  axis_block_sigs;
    logic [2:0]  inst_idle_sigs;
    logic [0:0]  inst_block_sigs;
    logic        block;
    logic [1:0]  blk_axis;
    logic [31:0] blk_cycles;

    kernel_stall_detector #(
        .AXIS_W(2), .IDLE_W(3), .BLK_W(1), .THRESHOLD(TH)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .axis_block_sigs (axis_block_sigs),
        .inst_idle_sigs  (inst_idle_sigs),
        .inst_block_sigs (inst_block_sigs),
        .block           (block),
        .blk_axis        (blk_axis),
        .blk_cycles      (blk_cycles)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        blk;
        logic [1:0]  axis;
        logic [31:0] cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Reference model: length of the current run of stall cycles sharing one signature.
    int          m_run  = 0;
    logic        m_blk  = 1'b0;
    logic [1:0]  m_axis = '0;
    logic [31:0] m_cyc  = '0;
    logic [2:0]  m_prev = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic cyc(input logic r, input logic [1:0] ax, input logic [2:0] idl, input logic bk);
        logic       st;
        logic [2:0] s;
        reset           = r;
        axis_block_sigs = ax;
        inst_idle_sigs  = idl;
        inst_block_sigs = bk;
        st = ((ax != 2'b00) || bk) && (idl != 3'b111);
        s  = {ax, bk};
        if (r) begin
            m_run = 0; m_blk = 1'b0; m_axis = '0; m_cyc = '0; m_prev = '0;
        end else begin
            if (m_blk) begin
`ifdef DEADLOCK_STICKY_EN
                if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
`else
                if (st && s == m_prev) begin
                    if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
                end else begin
                    m_blk = 1'b0;
                    m_run = 0;
                end
`endif
            end else begin
                if (st && m_run > 0 && s == m_prev) m_run++;
                else if (st && m_run == 0)          m_run = 1;
                else                                m_run = 0;
                if (m_run == TH + 1) begin
                    m_blk = 1'b1; m_axis = ax; m_cyc = 32'd1; m_run = 0;
                end
            end
            m_prev = s;
        end
        exp_q.push_back('{m_blk, m_axis, m_cyc});
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_block",      {31'd0, block}, {31'd0, e.blk});
            chk("sb_blk_axis",   {30'd0, blk_axis}, {30'd0, e.axis});
            chk("sb_blk_cycles", blk_cycles, e.cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(1, 2'b00, 3'b000, 0);
        cyc(1, 2'b00, 3'b000, 0);
        chk("reset_block", {31'd0, block}, 32'd0);
        chk("reset_cycles", blk_cycles, 32'd0);

        // Constant stall: block after TH+1 edges, then hold or release.
        for (int i = 0; i < TH + 1; i++) cyc(0, 2'b01, 3'b001, 0);
        chk("const_block", {31'd0, block}, 32'd1);
        chk("const_axis", {30'd0, blk_axis}, 32'd1);
        chk("const_cycles", blk_cycles, 32'd1);
        for (int i = 0; i < 9; i++) cyc(0, 2'b01, 3'b001, 0);
        chk("blocked10_cycles", blk_cycles, 32'd10);
`ifdef DEADLOCK_STICKY_EN
        for (int i = 0; i < 3; i++) cyc(0, 2'b00, 3'b001, 0);
        chk("sticky_block", {31'd0, block}, 32'd1);
        chk("sticky_cycles", blk_cycles, 32'd13);
        cyc(1, 2'b00, 3'b001, 0);
        chk("sticky_rst_block", {31'd0, block}, 32'd0);
        chk("sticky_rst_axis", {30'd0, blk_axis}, 32'd0);
        chk("sticky_rst_cycles", blk_cycles, 32'd0);
`else
        cyc(0, 2'b00, 3'b001, 0);
        chk("release_block", {31'd0, block}, 32'd0);
        chk("release_cycles", blk_cycles, 32'd10);
        chk("release_axis", {30'd0, blk_axis}, 32'd1);
`endif

        // Signature change restarts counting.
        cyc(1, 2'b00, 3'b000, 0);
        for (int i = 0; i < 3; i++) cyc(0, 2'b01, 3'b001, 0);
        for (int i = 0; i < 5; i++) cyc(0, 2'b10, 3'b001, 0);
        chk("toggle_not_yet", {31'd0, block}, 32'd0);
        cyc(0, 2'b10, 3'b001, 0);
        chk("toggle_block", {31'd0, block}, 32'd1);
        chk("toggle_axis", {30'd0, blk_axis}, 32'd2);

        // All instances idle masks every blocking flag.
        cyc(1, 2'b00, 3'b000, 0);
        for (int i = 0; i < 100; i++) cyc(0, 2'b11, 3'b111, 1);
        chk("all_idle_block", {31'd0, block}, 32'd0);

        // Reset in SUSPECT with cnt=3 forces a full fresh run.
        cyc(1, 2'b00, 3'b000, 0);
        for (int i = 0; i < 3; i++) cyc(0, 2'b01, 3'b000, 1);
        cyc(1, 2'b01, 3'b000, 1);
        for (int i = 0; i < TH; i++) cyc(0, 2'b01, 3'b000, 1);
        chk("rst_suspect_not_yet", {31'd0, block}, 32'd0);
        cyc(0, 2'b01, 3'b000, 1);
        chk("rst_suspect_block", {31'd0, block}, 32'd1);

        // Randomized segments of held inputs.
        for (int seg = 0; seg < 80; seg++) begin
            logic [1:0] ax;
            logic [2:0] idl;
            logic       bk;
            int         len;
            ax  = 2'($urandom_range(0, 3));
            bk  = 1'($urandom_range(0, 1));
            idl = ($urandom_range(0, 4) == 0) ? 3'b111 : 3'($urandom_range(0, 6));
            len = $urandom_range(1, 14);
            if ($urandom_range(0, 15) == 0) cyc(1, ax, idl, bk);
            for (int k = 0; k < len; k++) cyc(0, ax, idl, bk);
        end

        @(negedge clock);
        @(negedge clock);
        chk("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
